instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that sits directly downstream of the 64-bit × 256 instruction SRAM. It drives one SRAM port to read a contiguous, wrap-capable range of instruction words and delivers them in order to the decoder over a valid/ready handshake. It uses a small skid FIFO and credit accounting so the 1-cycle SRAM read latency never drops or duplicates a word under consumer back-pressure.

## Interface
- `ADDR_W`, default 8: instruction SRAM address width.
- `INSTR_W`, default 64: instruction word width.
- `FIFO_DEPTH`, default 2: skid FIFO entries; minimum 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin fetching; honoured only in IDLE.
- `start_pc`  in  ADDR_W  first address; sampled with `start`.
- `end_pc`  in  ADDR_W  last address, inclusive; sampled with `start`.
- `flush`  in  1  synchronous abort; returns the block to IDLE.
- `mem_en`  out  1  SRAM port enable (read-only; `we` is tied 0 externally).
- `mem_addr`  out  ADDR_W  SRAM read address.
- `mem_rdata`  in  INSTR_W  SRAM read data, valid the cycle after `mem_en`.
- `instr`  out  INSTR_W  instruction to the decoder.
- `instr_pc`  out  ADDR_W  address of `instr`.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decoder accepts the word.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the last word is accepted.

## Operation
- States:
  - IDLE → FETCH on `start`.
  - FETCH → DRAIN in the cycle the read of `end_pc` is issued.
  - DRAIN → IDLE when the FIFO is empty and nothing is in flight.
  - `done` pulses on the DRAIN → IDLE transition.
- Word count = ((`end_pc` − `start_pc`) mod 2^ADDR_W) + 1. The PC increments modulo 2^ADDR_W, so 255 → 0 wraps.
- `start_pc` == `end_pc` fetches exactly one word. A full 256-word range is not expressible and is out of scope.
- Read issue rule:
  - Credit = FIFO occupancy + in-flight reads − (pop this cycle).
  - `mem_en` is asserted in FETCH only when credit < FIFO_DEPTH.
  - Each issued read writes `{pc, mem_rdata}` into the FIFO on the next cycle.
- Handshake:
  - A transfer occurs when `instr_valid` && `instr_ready`.
  - `instr` and `instr_pc` hold stable while valid and not ready.
  - `instr_valid` never drops without a transfer, except on flush or reset.
- `start` while busy is ignored.
- `flush`, in any state:
  - next cycle the state is IDLE, the FIFO is empty, and `instr_valid` = 0;
  - a read issued in the flush cycle or the cycle before is discarded on arrival;
  - no `done` pulse.
- `flush` and `start` in the same cycle: flush wins and `start` is dropped.

## Timing
- Reset values: `mem_en` = 0, `mem_addr` = 0, `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `busy` = 0, `done` = 0. State is IDLE, FIFO is empty.
- `mem_addr` and `mem_en` are registered. First `mem_en` is in cycle S+1 after `start` in cycle S.
- First `instr_valid` is in cycle S+2. Start-to-first-instruction latency is 2 cycles.
- With `instr_ready` held high, throughput is 1 word/cycle. N words complete with `done` in cycle S+N+2.
- Back-pressure: at most FIFO_DEPTH words are issued-or-buffered. Issue resumes in the cycle after a pop frees credit.
- Reset asserted mid-operation clears everything asynchronously. Late SRAM data after reset release is ignored, because the in-flight count is zero.

## Configuration
- `IFETCH_PERF_EN`
  - defined: adds output `perf_stall_cycles` (32 bits), which counts cycles with `instr_valid` && !`instr_ready` while busy. It clears on `start`, saturates at all-ones, and resets to 0.
  - undefined: the port and counter are absent.

## Structure
- Package `ifetch_pkg`:
  - `ifetch_state_t` enum (IDLE, FETCH, DRAIN);
  - default constants `IMEM_ADDR_W` = 8 and `INSTR_W` = 64;
  - an entry typedef `{pc, instr}`.
- Sub-module `ifetch_fifo`: synchronous, parameterised depth, push/pop/full/empty/count. Simultaneous push and pop when full is legal; simultaneous push and pop when empty is handled by pushing first.
- Top level holds the FSM, PC/end registers, in-flight/discard tracking, and the optional perf counter.

## Test plan
- `start_pc` = 0x10, `end_pc` = 0x13, ready always high → words at 0x10–0x13 in order on consecutive cycles, first valid at S+2, `done` at S+6.
- `start_pc` = 0xFE, `end_pc` = 0x01 → `instr_pc` sequence FE, FF, 00, 01; exactly 4 transfers.
- Range 0x20–0x27 with `instr_ready` toggling 1,0,0,1,… → no loss or duplication, data stable during stalls, never more than 2 issued-or-buffered; with `IFETCH_PERF_EN`, the stall counter equals the ready-low valid cycles.
- `flush` in cycle S+3 of range 0x00–0x0F → IDLE next cycle, `instr_valid` low, no `done`; a new `start` at 0x40 returns 0x40 first, with no stale words.
- `start_pc` = `end_pc` = 0x80 → exactly one transfer, then `done`; a second `start` during busy is ignored.
- `rst_n` low mid-fetch → all outputs at reset values immediately; after release, a new fetch of 0x05–0x06 is correct.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding, default widths and FIFO entry type
// for the instruction fetch stage.
package ifetch_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } ifetch_state_t;

  // One buffered instruction together with the address it was read from.
  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]     instr;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO with a combinational head.
// Push and pop in the same cycle are legal when full (the head leaves as the
// new word lands) and when empty (the word is pushed first, then popped).
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 72,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: reads a wrap-capable address range from the instruction SRAM
// and delivers {pc, instr} in order over valid/ready. A word arriving from
// the SRAM is handed straight to the decoder when the skid FIFO is empty,
// otherwise it is queued; credit accounting keeps issued-or-buffered words
// within FIFO_DEPTH so nothing is dropped under back-pressure.
// Build option: define IFETCH_PERF_EN to add the perf_stall_cycles output.
module instr_fetch #(
  parameter int ADDR_W     = ifetch_pkg::IMEM_ADDR_W,
  parameter int INSTR_W    = ifetch_pkg::INSTR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic [ADDR_W-1:0]  end_pc,
  input  logic               flush,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles
`endif
);

  import ifetch_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = CNT_W + 1;
  localparam int ENT_W  = ADDR_W + INSTR_W;

  ifetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   rd_pc_q, rd_pc_d;
  logic                done_q, done_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic [ENT_W-1:0]    fifo_wdata;
  logic [ENT_W-1:0]    fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  logic                xfer;
  logic                start_ok;
  logic [CRED_W-1:0]   credit;

  // A word is presented either from the FIFO head or straight off the SRAM.
  assign instr_valid = !fifo_empty || rd_vld_q;
  assign xfer        = instr_valid && instr_ready;
  assign start_ok    = start && !flush && (state_q == IDLE);

  // Arriving word is queued unless it goes straight to the decoder.
  assign fifo_push  = rd_vld_q && !(fifo_empty && instr_ready);
  assign fifo_pop   = !fifo_empty && instr_ready;
  assign fifo_wdata = {rd_pc_q, mem_rdata};

  // Words that will still be owed after this cycle: buffered + arriving now
  // + read issued this cycle, less the word the decoder takes now.
  assign credit = CRED_W'(fifo_count) + CRED_W'(rd_vld_q) + CRED_W'(mem_en_q)
                - CRED_W'(xfer);

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output mux: FIFO head has priority since it is older than any arrival.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!fifo_empty) begin
      {instr_pc, instr} = fifo_rdata;
    end else if (rd_vld_q) begin
      instr_pc = rd_pc_q;
      instr    = mem_rdata;
    end
  end

  // FSM next-state, read issue and done generation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    end_d      = end_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_vld_d   = mem_en_q;
    rd_pc_d    = mem_addr_q;
    done_d     = 1'b0;
    if (flush) begin
      // The read issued now would land next cycle; drop it on arrival.
      state_d  = IDLE;
      rd_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d    = FETCH;
            mem_en_d   = 1'b1;
            mem_addr_d = start_pc;
            pc_d       = start_pc + ADDR_W'(1);
            end_d      = end_pc;
          end
        end
        FETCH: begin
          if (mem_en_q && (mem_addr_q == end_q)) begin
            state_d = DRAIN;
          end else if ((credit < CRED_W'(FIFO_DEPTH)) && !fifo_full) begin
            mem_en_d   = 1'b1;
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (credit == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, address and read-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      end_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_pc_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      end_q      <= end_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_pc_q    <= rd_pc_d;
      done_q     <= done_d;
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Stall counter: cleared by an accepted start, saturating.
  always_comb begin
    perf_d = perf_q;
    if (start_ok) begin
      perf_d = '0;
    end else if (busy && instr_valid && !instr_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed tests with a scoreboard. Stimulus pushes the
// expected {pc, instr} words; a negedge monitor pops and compares on every
// transfer and also watches hold stability and the issued-or-buffered limit.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic [7:0]  end_pc = '0;
  logic        flush = 1'b0;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [63:0] mem_rdata = '0;
  logic [63:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int stall_model = 0;
  int outstanding = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  ifetch_entry_t exp_q[$];
  ifetch_entry_t held;
  logic hold_pend = 1'b0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .end_pc      (end_pc),
    .flush       (flush),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [63:0] word_of(input logic [7:0] a);
    return {a, 8'h5A, ~a, 40'h0123456789};
  endfunction

  // SRAM model: one-cycle registered read.
  always @(posedge clk) if (mem_en) mem_rdata <= word_of(mem_addr);

  // Ready driver: always high, or the 1,0,0 repeating pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        instr_ready = 1'b1;
      end else begin
        instr_ready = (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_pc(input logic [7:0] pc);
    ifetch_entry_t e;
    e.pc    = pc;
    e.instr = word_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] sp, input logic [7:0] ep, output int s);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_pc = sp;
    end_pc = ep;
    s = cycle_cnt;
    stall_model = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        cyc = cycle_cnt;
        break;
      end
    end
    if (cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done within %0d cycles", budget);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      outstanding = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_pc", instr_pc, held.pc);
        chk("hold_instr", instr, held.instr);
      end
      if (mem_en) outstanding++;
      if (busy) begin
        checks++;
        if (outstanding > 2) begin
          errors++;
          $display("FAIL issued_or_buffered actual=%0d required<=2", outstanding);
        end
      end
      if (busy && instr_valid && !instr_ready) stall_model++;
      if (instr_valid && instr_ready) begin
        xfer_cnt++;
        $display("xfer cyc=%0d pc=%02h instr=%016h", cycle_cnt, instr_pc, instr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer actual pc=%02h required=no transfer", instr_pc);
        end else begin
          ifetch_entry_t e;
          e = exp_q.pop_front();
          chk("xfer_pc", instr_pc, e.pc);
          chk("xfer_instr", instr, e.instr);
        end
        outstanding--;
      end
      if (done) begin
        done_cnt++;
        $display("done cyc=%0d", cycle_cnt);
      end
      hold_pend = instr_valid && !instr_ready && !flush;
      held.pc = instr_pc;
      held.instr = instr;
      if (flush) outstanding = 0;
    end
  end

  // Watchdog: the directed tests finish in a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, dc, x0, d0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_instr", instr, 64'h0);
    chk("rst_instr_pc", instr_pc, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: 0x10..0x13, ready high, latency and throughput.
    x0 = xfer_cnt; d0 = done_cnt;
    push_pc(8'h10); push_pc(8'h11); push_pc(8'h12); push_pc(8'h13);
    do_start(8'h10, 8'h13, s);
    @(negedge clk); #1;
    chk("t1_mem_en_s1", mem_en, 1'b1);
    chk("t1_mem_addr_s1", mem_addr, 8'h10);
    chk("t1_valid_s1", instr_valid, 1'b0);
    chk("t1_busy_s1", busy, 1'b1);
    @(negedge clk); #1;
    chk("t1_valid_s2", instr_valid, 1'b1);
    chk("t1_pc_s2", instr_pc, 8'h10);
    wait_done(20, dc);
    chk("t1_done_cycle", dc - s, 6);
    chk("t1_xfers", xfer_cnt - x0, 4);
    chk("t1_left", exp_q.size(), 0);
    @(negedge clk); #1;
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_idle", busy, 1'b0);

    // 2: wrap FE, FF, 00, 01.
    x0 = xfer_cnt;
    push_pc(8'hFE); push_pc(8'hFF); push_pc(8'h00); push_pc(8'h01);
    do_start(8'hFE, 8'h01, s);
    wait_done(20, dc);
    chk("t2_done_cycle", dc - s, 6);
    chk("t2_xfers", xfer_cnt - x0, 4);
    chk("t2_left", exp_q.size(), 0);

    // 3: 0x20..0x27 with ready 1,0,0 repeating.
    @(negedge clk); #1;
    ready_mode = 1; ready_phase = 0;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) push_pc(8'h20 + 8'(i));
    do_start(8'h20, 8'h27, s);
    wait_done(200, dc);
    chk("t3_xfers", xfer_cnt - x0, 8);
    chk("t3_left", exp_q.size(), 0);
`ifdef IFETCH_PERF_EN
    chk("t3_perf_stalls", perf_stall_cycles, 32'(stall_model));
`endif
    @(negedge clk); #1;
    ready_mode = 0;
    repeat (2) @(posedge clk);

    // 4: flush in S+3 of 0x00..0x0F, then restart at 0x40.
    x0 = xfer_cnt; d0 = done_cnt;
    push_pc(8'h00); push_pc(8'h01);
    do_start(8'h00, 8'h0F, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk); #1;
    chk("t4_busy_after_flush", busy, 1'b0);
    chk("t4_valid_after_flush", instr_valid, 1'b0);
    chk("t4_mem_en_after_flush", mem_en, 1'b0);
    chk("t4_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_xfers", xfer_cnt - x0, 2);
    push_pc(8'h40); push_pc(8'h41); push_pc(8'h42); push_pc(8'h43);
    do_start(8'h40, 8'h43, s);
    wait_done(20, dc);
    chk("t4_restart_done_cycle", dc - s, 6);
    chk("t4_restart_left", exp_q.size(), 0);

    // 5: single word 0x80, second start while busy ignored.
    x0 = xfer_cnt; d0 = done_cnt;
    push_pc(8'h80);
    do_start(8'h80, 8'h80, s);
    start = 1'b1; start_pc = 8'h90; end_pc = 8'h95;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, dc);
    chk("t5_done_cycle", dc - s, 3);
    repeat (6) @(negedge clk);
    #1;
    chk("t5_xfers", xfer_cnt - x0, 1);
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_idle", busy, 1'b0);
    chk("t5_left", exp_q.size(), 0);

    // 6: reset mid-fetch, then 0x05..0x06.
    for (int i = 0; i < 16; i++) push_pc(8'h30 + 8'(i));
    do_start(8'h30, 8'h3F, s);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_en", mem_en, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 8'h00);
    chk("t6_rst_instr", instr, 64'h0);
    chk("t6_rst_instr_pc", instr_pc, 8'h00);
    chk("t6_rst_valid", instr_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    x0 = xfer_cnt;
    push_pc(8'h05); push_pc(8'h06);
    do_start(8'h05, 8'h06, s);
    wait_done(20, dc);
    chk("t6_done_cycle", dc - s, 4);
    chk("t6_xfers", xfer_cnt - x0, 2);
    chk("t6_left", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
